pll_reset_ctrl: RTL and testbench

PLL_RESET_CTRL -- requirements
Module: pll_reset_ctrl

---
 rtl/pll_reset_ctrl.sv | 90 +++++++++
 tb/tb_pll_reset_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/pll_reset_ctrl.sv
// pll_reset_ctrl: PLL reset pulse, lock qualification and downstream reset sequencing.
// Ports: clk (refclk), rst (sync, active-high), locked (async PLL lock),
//        pll_rst (PLL reset request), sys_reset (low only in RUN), ready (high only in RUN),
//        relock_count (saturating count of lock losses seen in RUN).
// Optional macro PLL_RESET_CTRL_LOSS_FILTER_EN: lock loss in RUN needs 4 consecutive low cycles.
// LOCK_STABLE_CYCLES must be at least 2; the WAIT_LOCK cycle that sees lock counts as the first.
module pll_reset_ctrl #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int SYNC_STAGES         = 2
)(
  input  logic       clk,
  input  logic       rst,
  input  logic       locked,
  output logic       pll_rst,
  output logic       sys_reset,
  output logic       ready,
  output logic [7:0] relock_count
);
  localparam int M1 = PLL_RST_CYCLES > LOCK_STABLE_CYCLES ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAXP = M1 > LOCK_TIMEOUT_CYCLES ? M1 : LOCK_TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAXP) + 1;
  localparam logic [1:0] PLL_RESET = 2'd0;
  localparam logic [1:0] WAIT_LOCK = 2'd1;
  localparam logic [1:0] STABLE    = 2'd2;
  localparam logic [1:0] RUN       = 2'd3;
  logic [SYNC_STAGES-1:0] sync;
  logic                   locked_s;
  logic [1:0]             state, state_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic                   loss;
  assign locked_s = sync[SYNC_STAGES-1];
`ifdef PLL_RESET_CTRL_LOSS_FILTER_EN
  // in RUN the counter tracks consecutive low lock samples
  assign loss = !locked_s && cnt == CW'(3);
`else
  assign loss = !locked_s;
`endif
  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    case (state)
      PLL_RESET: if (cnt == CW'(PLL_RST_CYCLES - 1)) begin
        state_n = WAIT_LOCK;
        cnt_n   = '0;
      end
      WAIT_LOCK: if (locked_s) begin
        state_n = STABLE;
        cnt_n   = '0;
      end else if (cnt == CW'(LOCK_TIMEOUT_CYCLES - 1)) begin
        state_n = PLL_RESET;
        cnt_n   = '0;
      end
      STABLE: if (!locked_s) begin
        state_n = WAIT_LOCK;
        cnt_n   = '0;
      end else if (cnt == CW'(LOCK_STABLE_CYCLES - 2)) begin
        state_n = RUN;
        cnt_n   = '0;
      end
      RUN: if (loss) begin
        state_n = PLL_RESET;
        cnt_n   = '0;
      end else begin
        cnt_n = locked_s ? '0 : cnt + CW'(1);
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync         <= '0;
      state        <= PLL_RESET;
      cnt          <= '0;
      pll_rst      <= 1'b1;
      sys_reset    <= 1'b1;
      ready        <= 1'b0;
      relock_count <= '0;
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], locked};
      state     <= state_n;
      cnt       <= cnt_n;
      pll_rst   <= state_n == PLL_RESET;
      sys_reset <= state_n != RUN;
      ready     <= state_n == RUN;
      if (state == RUN && loss && relock_count != 8'hff)
        relock_count <= relock_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_pll_reset_ctrl.sv
// tb_pll_reset_ctrl: scoreboard bench with a cycle-level behavioural model of the reset sequencer.
module tb_pll_reset_ctrl;
  localparam int PR = 4, LS = 8, TO = 32;
`ifdef PLL_RESET_CTRL_LOSS_FILTER_EN
  localparam int LOSS_N = 4;
`else
  localparam int LOSS_N = 1;
`endif
  typedef struct packed {logic p; logic s; logic r; logic [7:0] c;} exp_t;
  logic clk = 1'b0, rst = 1'b1, locked = 1'b0;
  logic pll_rst, sys_reset, ready;
  logic [7:0] relock_count;
  exp_t q[$];
  int checks = 0, passed = 0;
  int mode = 0, el = 0, streak = 0, zs = 0, relock = 0;
  logic sh1 = 1'b0, sh2 = 1'b0;
  pll_reset_ctrl #(.PLL_RST_CYCLES(PR), .LOCK_STABLE_CYCLES(LS), .LOCK_TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .locked(locked), .pll_rst(pll_rst),
    .sys_reset(sys_reset), .ready(ready), .relock_count(relock_count)
  );
  always #5 clk = ~clk;
  // mode: 0 pulsing the PLL, 1 waiting for lock, 2 qualifying lock, 3 running
  task automatic model(input logic r, input logic l);
    logic ls;
    exp_t e;
    ls = sh2;
    if (r) begin
      mode = 0; el = 0; streak = 0; zs = 0; relock = 0; sh1 = 1'b0; sh2 = 1'b0;
    end else begin
      sh2 = sh1;
      sh1 = l;
      if (mode == 0) begin
        el++;
        if (el == PR) begin mode = 1; el = 0; end
      end else if (mode == 1) begin
        if (ls) begin mode = 2; streak = 1; end
        else begin
          el++;
          if (el == TO) begin mode = 0; el = 0; end
        end
      end else if (mode == 2) begin
        if (!ls) begin mode = 1; el = 0; end
        else begin
          streak++;
          if (streak == LS) begin mode = 3; zs = 0; end
        end
      end else begin
        zs = ls ? 0 : zs + 1;
        if (zs == LOSS_N) begin
          mode = 0; el = 0;
          if (relock < 255) relock++;
        end
      end
    end
    e = {mode == 0, mode != 3, mode == 3, 8'(relock)};
    q.push_back(e);
  endtask
  task automatic step(input logic r, input logic l);
    rst = r;
    locked = l;
    @(posedge clk);
    model(r, l);
    #1;
  endtask
  task automatic chk(input string n, input int got, input int want);
    checks++;
    if (got == want) passed++;
    else $display("FAIL %s got %0d expected %0d", n, got, want);
  endtask
  initial forever begin
    @(negedge clk);
    if (q.size() > 0) begin
      exp_t e, a;
      e = q.pop_front();
      a = {pll_rst, sys_reset, ready, relock_count};
      checks++;
      if (a === e) passed++;
      else $display("FAIL outputs t=%0t got pll_rst=%b sys_reset=%b ready=%b relock=%0d expected pll_rst=%b sys_reset=%b ready=%b relock=%0d",
                    $time, a.p, a.s, a.r, a.c, e.p, e.s, e.r, e.c);
    end
  end
  initial begin
    repeat (2) step(1'b1, 1'b0);
    chk("reset_pll_rst", int'(pll_rst), 1);
    chk("reset_ready", int'(ready), 0);
    for (int c = 0; c < 40; c++) begin
      step(1'b0, c >= 10);
      if (c == 2) chk("bringup_pll_rst_c3", int'(pll_rst), 1);
      if (c == 3) chk("bringup_pll_rst_c4", int'(pll_rst), 0);
      if (c == 18) chk("bringup_sys_reset_c19", int'(sys_reset), 1);
      if (c == 19) chk("bringup_ready_c20", int'(ready), 1);
    end
    chk("bringup_relock", int'(relock_count), 0);
    repeat (2) step(1'b1, 1'b0);
    for (int c = 0; c < 120; c++) begin
      step(1'b0, 1'b0);
      if (c == 34) chk("timeout_pll_rst_c35", int'(pll_rst), 0);
      if (c == 35) chk("timeout_pll_rst_c36", int'(pll_rst), 1);
    end
    chk("timeout_sys_reset", int'(sys_reset), 1);
    chk("timeout_relock", int'(relock_count), 0);
    repeat (2) step(1'b1, 1'b0);
    for (int c = 0; c < 40; c++) begin
      step(1'b0, c >= 10 && c != 16);
      if (c == 25) chk("chatter_ready_c26", int'(ready), 0);
      if (c == 26) chk("chatter_ready_c27", int'(ready), 1);
    end
    repeat (2) step(1'b1, 1'b0);
    for (int c = 0; c < 40; c++) step(1'b0, c >= 10);
    step(1'b0, 1'b0);
    for (int d = 0; d < 30; d++) begin
      step(1'b0, 1'b1);
      if (d == 1) begin
        chk("loss1_pll_rst", int'(pll_rst), LOSS_N == 1 ? 1 : 0);
        chk("loss1_sys_reset", int'(sys_reset), LOSS_N == 1 ? 1 : 0);
        chk("loss1_relock", int'(relock_count), LOSS_N == 1 ? 1 : 0);
      end
    end
    repeat (4) step(1'b0, 1'b0);
    repeat (30) step(1'b0, 1'b1);
    chk("loss4_relock", int'(relock_count), LOSS_N == 1 ? 2 : 1);
    repeat (3) step(1'b0, 1'b0);
    repeat (30) step(1'b0, 1'b1);
    chk("loss3_relock", int'(relock_count), LOSS_N == 1 ? 3 : 1);
    repeat (2) step(1'b1, 1'b0);
    for (int c = 0; c < 40; c++) step(1'b0, c >= 10);
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(4, 6)) step(1'b0, 1'b0);
      repeat ($urandom_range(24, 36)) step(1'b0, 1'b1);
    end
    chk("saturate_relock", int'(relock_count), 255);
    chk("saturate_ready", int'(ready), 1);
    step(1'b1, 1'b1);
    chk("midrst_pll_rst", int'(pll_rst), 1);
    chk("midrst_sys_reset", int'(sys_reset), 1);
    chk("midrst_relock", int'(relock_count), 0);
    for (int c = 0; c < 40; c++) step(1'b0, 1'b1);
    chk("midrst_ready_again", int'(ready), 1);
    for (int i = 0; i < 150; i++) begin
      logic lv;
      int len;
      lv = $urandom_range(0, 3) != 0;
      len = lv ? $urandom_range(1, 60) : ($urandom_range(0, 4) == 0 ? $urandom_range(30, 80) : $urandom_range(1, 6));
      for (int j = 0; j < len; j++) step($urandom_range(0, 399) == 0, lv);
    end
    repeat (2) @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
